// File: rtl/board_state.sv
// Minesweeper board state: flag/reveal masks, flood merge, chord reveal FSM,
// flag/reveal counters and sticky lose/win detection.
module board_state #(
    parameter int GRID_W      = 8,
    parameter int GRID_H      = 8,
    parameter int TOTAL_TILES = GRID_W * GRID_H,
    parameter int INDEX_BITS  = $clog2(TOTAL_TILES),
    parameter int CNT_BITS    = $clog2(TOTAL_TILES + 1),
    parameter int NUM_MINES   = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  tile_index,
    input  logic                   flag,
    input  logic                   reveal,
    input  logic                   chord,
    input  logic [3:0]             cursor_count,
    input  logic [TOTAL_TILES-1:0] mine_map,
    input  logic [TOTAL_TILES-1:0] flood_update,
    input  logic                   flood_apply,
    output logic [TOTAL_TILES-1:0] flagged,
    output logic [TOTAL_TILES-1:0] revealed,
    output logic [CNT_BITS-1:0]    flag_count,
    output logic [CNT_BITS-1:0]    revealed_count,
    output logic                   busy,
    output logic                   mine_hit,
    output logic                   win
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;
    localparam logic [CNT_BITS-1:0]   WIN_TARGET = CNT_BITS'(TOTAL_TILES - NUM_MINES);
    localparam logic [INDEX_BITS:0]   TILE_LIMIT = (INDEX_BITS + 1)'(TOTAL_TILES);

    // Returns {in_bounds, neighbour index} for neighbour k of idx (no row wrap).
    function automatic logic [INDEX_BITS:0] nbr_f(input logic [INDEX_BITS-1:0] idx,
                                                  input logic [2:0] k);
        int x, y, dx, dy, nx, ny;
        x = int'(idx) % GRID_W;
        y = int'(idx) / GRID_W;
        case (k)
            3'd0:    begin dx = -1; dy = -1; end
            3'd1:    begin dx =  0; dy = -1; end
            3'd2:    begin dx =  1; dy = -1; end
            3'd3:    begin dx = -1; dy =  0; end
            3'd4:    begin dx =  1; dy =  0; end
            3'd5:    begin dx = -1; dy =  1; end
            3'd6:    begin dx =  0; dy =  1; end
            3'd7:    begin dx =  1; dy =  1; end
            default: begin dx =  0; dy =  0; end
        endcase
        nx = x + dx;
        ny = y + dy;
        if (nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H) begin
            return {1'b1, INDEX_BITS'(ny * GRID_W + nx)};
        end else begin
            return {(INDEX_BITS + 1){1'b0}};
        end
    endfunction

    function automatic logic [TOTAL_TILES-1:0] nbr_mask_f(input logic [INDEX_BITS-1:0] idx);
        logic [TOTAL_TILES-1:0] m;
        logic [INDEX_BITS:0]    n;
        m = '0;
        for (int k = 0; k < 8; k++) begin
            n = nbr_f(idx, 3'(k));
            if (n[INDEX_BITS]) begin
                m[n[INDEX_BITS-1:0]] = 1'b1;
            end else begin
                m = m;
            end
        end
        return m;
    endfunction

    function automatic logic [CNT_BITS-1:0] popcount_f(input logic [TOTAL_TILES-1:0] v);
        logic [CNT_BITS-1:0] c;
        c = '0;
        for (int i = 0; i < TOTAL_TILES; i++) begin
            c = c + {{(CNT_BITS - 1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [TOTAL_TILES-1:0] flagged_r, revealed_r;
    logic [CNT_BITS-1:0]    flag_count_r, revealed_count_r;
    logic                   mine_hit_r, win_r, busy_r;
    logic                   prev_flag_r, prev_reveal_r, prev_chord_r;
    logic [1:0]             state_r;
    logic [2:0]             k_r;
    logic [3:0]             acc_r, cnt_r;
    logic [INDEX_BITS-1:0]  idx_r;

    logic                   locked_s, accept_s, do_chord_s, do_flag_s, do_reveal_s;
    logic [INDEX_BITS:0]    nbr_s;
    logic                   nbr_flag_s;
    logic [TOTAL_TILES-1:0] flag_next_s, reveal_add_s, revealed_next_s;
    logic [CNT_BITS-1:0]    flag_cnt_next_s;
    logic                   hit_s;

    assign locked_s    = mine_hit_r | win_r;
    assign accept_s    = ~busy_r & ~locked_s & ({1'b0, tile_index} < TILE_LIMIT);
    assign do_chord_s  = accept_s & chord & ~prev_chord_r;
    assign do_flag_s   = accept_s & flag & ~prev_flag_r & ~do_chord_s;
    assign do_reveal_s = accept_s & reveal & ~prev_reveal_r & ~(chord & ~prev_chord_r)
                         & ~(flag & ~prev_flag_r);
    assign nbr_s       = nbr_f(idx_r, k_r);
    assign nbr_flag_s  = nbr_s[INDEX_BITS] & flagged_r[nbr_s[INDEX_BITS-1:0]];

    // Next flag/reveal masks from requests, flood merge and chord apply.
    always_comb begin
        flag_next_s     = flagged_r;
        flag_cnt_next_s = flag_count_r;
        reveal_add_s    = '0;
        if (do_flag_s && !revealed_r[tile_index]) begin
            flag_next_s[tile_index] = ~flagged_r[tile_index];
            if (flagged_r[tile_index]) begin
                flag_cnt_next_s = flag_count_r - CNT_BITS'(1);
            end else begin
                flag_cnt_next_s = flag_count_r + CNT_BITS'(1);
            end
        end else begin
            flag_next_s = flagged_r;
        end
        if (do_reveal_s) begin
            reveal_add_s[tile_index] = 1'b1;
        end else begin
            reveal_add_s = reveal_add_s;
        end
        if (flood_apply && !locked_s) begin
            reveal_add_s = reveal_add_s | flood_update;
        end else begin
            reveal_add_s = reveal_add_s;
        end
        if (state_r == ST_APPLY && !locked_s && revealed_r[idx_r] && acc_r == cnt_r) begin
            reveal_add_s = reveal_add_s | nbr_mask_f(idx_r);
        end else begin
            reveal_add_s = reveal_add_s;
        end
        revealed_next_s = revealed_r | (reveal_add_s & ~flagged_r);
        hit_s           = |(revealed_next_s & mine_map);
    end

    // Chord sequencer: latch, count flagged neighbours over 8 cycles, apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            k_r     <= 3'd0;
            acc_r   <= 4'd0;
            cnt_r   <= 4'd0;
            idx_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (do_chord_s) begin
                        state_r <= ST_COUNT;
                        busy_r  <= 1'b1;
                        idx_r   <= tile_index;
                        cnt_r   <= cursor_count;
                        k_r     <= 3'd0;
                        acc_r   <= 4'd0;
                    end
                end
                ST_COUNT: begin
                    acc_r <= acc_r + {3'b000, nbr_flag_s};
                    k_r   <= k_r + 3'd1;
                    if (k_r == 3'd7) begin
                        state_r <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Board masks, counters, edge history and sticky outcome flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            flagged_r        <= '0;
            revealed_r       <= '0;
            flag_count_r     <= '0;
            revealed_count_r <= '0;
            mine_hit_r       <= 1'b0;
            win_r            <= 1'b0;
            prev_flag_r      <= 1'b1;
            prev_reveal_r    <= 1'b1;
            prev_chord_r     <= 1'b1;
        end else begin
            prev_flag_r      <= flag;
            prev_reveal_r    <= reveal;
            prev_chord_r     <= chord;
            revealed_count_r <= popcount_f(revealed_r);
            win_r            <= win_r | ((revealed_count_r == WIN_TARGET) & ~mine_hit_r);
            if (!locked_s) begin
                flagged_r    <= flag_next_s;
                flag_count_r <= flag_cnt_next_s;
                revealed_r   <= revealed_next_s;
                mine_hit_r   <= hit_s;
            end
        end
    end

    assign flagged        = flagged_r;
    assign revealed       = revealed_r;
    assign flag_count     = flag_count_r;
    assign revealed_count = revealed_count_r;
    assign busy           = busy_r;
    assign mine_hit       = mine_hit_r;
    assign win            = win_r;

endmodule

// File: doc/board_state.md
# board_state

Parametrised successor to the per-tile flag/reveal store for the minesweeper board. Holds persistent flag and reveal masks for a rectangular GRID_W x GRID_H board, applies cursor flag/reveal requests and flood-fill masks, and adds a multi-cycle chord reveal, flag and reveal counters, and sticky lose/win detection. Sits between the cursor/input debouncer, the flood-fill engine and the renderer.

## Interface
- GRID_W, 8, board columns (>=2)
- GRID_H, 8, board rows (>=2)
- TOTAL_TILES, GRID_W*GRID_H, tile count
- INDEX_BITS, $clog2(TOTAL_TILES), tile index width
- CNT_BITS, $clog2(TOTAL_TILES+1), counter width
- NUM_MINES, 10, mines on board (< TOTAL_TILES)

- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- tile_index  in  INDEX_BITS  cursor tile, index = y*GRID_W + x
- flag  in  1  toggle-flag request level (rising edge acts)
- reveal  in  1  reveal request level (rising edge acts)
- chord  in  1  chord request level (rising edge acts)
- cursor_count  in  4  adjacent-mine number of tile_index (0..8)
- mine_map  in  TOTAL_TILES  1 = mine at tile
- flood_update  in  TOTAL_TILES  flood-fill reveal mask
- flood_apply  in  1  flood_update valid this cycle
- flagged  out  TOTAL_TILES  persistent flag mask
- revealed  out  TOTAL_TILES  persistent reveal mask
- flag_count  out  CNT_BITS  number of set flagged bits
- revealed_count  out  CNT_BITS  popcount of revealed, registered
- busy  out  1  chord sequence in progress
- mine_hit  out  1  sticky: a mine tile became revealed
- win  out  1  sticky: all non-mine tiles revealed

## Operation
- Reset: flagged, revealed, flag_count, revealed_count = 0; busy, mine_hit, win = 0; FSM = IDLE; edge-detect prev registers = 1 (inputs held high through reset do not fire).
- Edge = input high this cycle AND prev low. One request accepted per cycle, priority chord > flag > reveal; lower-priority edges that cycle are dropped.
- Requests ignored when busy, mine_hit or win is set, or tile_index >= TOTAL_TILES.
- Flag: toggles flagged[tile_index] only if revealed[tile_index]=0; flag_count +1 on set, -1 on clear.
- Reveal: sets revealed[tile_index] only if flagged[tile_index]=0.
- Flood: when flood_apply=1 and not locked (mine_hit/win), revealed |= flood_update & ~flagged. Accepted in any FSM state, merges with same-cycle request.
- mine_hit set at the edge where any bit of (new reveal mask & mine_map) is 1; revealed still updates that cycle.
- Lock: once mine_hit or win is 1, flagged/revealed/counters frozen until rst.
- Chord FSM: IDLE, COUNT, APPLY.
  - IDLE -> COUNT on accepted chord edge: latch idx, cursor_count; k=0, acc=0.
  - COUNT: neighbour k (dx,dy) order: (-1,-1),(0,-1),(1,-1),(-1,0),(1,0),(-1,1),(0,1),(1,1); acc += flagged[n] if in bounds, else 0; k++; after k=7 -> APPLY.
  - APPLY: if revealed[idx]=1 and acc == latched count, revealed |= in-bounds neighbours & ~flagged (mine check applies); -> IDLE unconditionally.
- Bounds: x = idx mod GRID_W, y = idx div GRID_W; neighbour out of bounds if x+dx or y+dy outside [0,GRID_W-1]/[0,GRID_H-1]; no row wrap.
- revealed_count = popcount(revealed) registered; win set when revealed_count == TOTAL_TILES-NUM_MINES and mine_hit=0.

## Timing
- Flag/reveal: input sampled high at edge t (low at t-1) -> flagged/revealed/flag_count/mine_hit updated after edge t.
- revealed_count lags revealed by 1 cycle (after t+1); win after t+2.
- Chord: edge accepted at t; COUNT occupies edges t+1..t+8; APPLY at edge t+9; busy = 1 after edge t through edge t+9, 0 after t+9; next request accepted at t+10 earliest.
- Request edges while busy are consumed (prev still tracks) and lost.
- rst mid-chord: FSM IDLE, busy 0, all state cleared after the reset edge.
- Flood and request same cycle: both ORed in one update.

## Test plan
- Reset with flag held high, release, re-press at tile 9 -> no toggle during hold; after press flagged[9]=1, flag_count=1; second press clears, flag_count=0.
- Flag tile 5 then reveal tile 5 -> revealed[5]=0; reveal tile 6 (no mine) -> revealed[6]=1 next cycle, revealed_count=1 one cycle later.
- Chord at corner tile 0, cursor_count=1, flag tile 1, revealed[0]=1 -> busy 10 cycles; after APPLY tiles 8,9 revealed, tile 1 stays flagged, no wrap to tile 7/15.
- Chord with acc != cursor_count -> revealed unchanged, busy drops after t+9; reveal edge during busy ignored.
- Flood mask 0xFF with flagged[3]=1 plus reveal of tile 20 same cycle -> revealed = 0xFF & ~bit3 | bit20.
- Reveal mine tile -> mine_hit=1 same edge; later flag/reveal/flood ignored; reveal all 54 safe tiles on fresh board (GRID 8x8, NUM_MINES 10) -> win=1 two cycles after last reveal.
